// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//   Clocked instruction memory with a request/response fetch port and a
//   run-time program-load port. It sits between the PC/IF stage and the
//   instruction register. Reads take 1+WAIT_STATES cycles. Alignment and range
//   faults are reported with the response. A program write that lands on the
//   capture edge is bypassed into the response.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   fetch_req_i    fetch request, sampled only while fetch_ready_o=1
//   fetch_addr_i   byte address of the instruction (PC)
//   fetch_ready_o  a request can be accepted this cycle
//   fetch_valid_o  one-cycle pulse: fetch_instr_o / fetch_fault_o are valid
//   fetch_instr_o  fetched instruction, held until the next response
//   fetch_fault_o  00 ok, 01 misaligned, 10 out of range
//   prog_we_i      program-load write strobe
//   prog_addr_i    byte address of the write
//   prog_data_i    write data
//   prog_err_o     one-cycle pulse: previous write was dropped
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    DEPTH       = 64,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_instr_o,
  output logic [1:0]            fetch_fault_o,
  input  logic                  prog_we_i,
  input  logic [ADDR_WIDTH-1:0] prog_addr_i,
  input  logic [DATA_WIDTH-1:0] prog_data_i,
  output logic                  prog_err_o
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]            WS      = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0]            F_OK    = 2'b00;
  localparam logic [1:0]            F_MIS   = 2'b01;
  localparam logic [1:0]            F_OOR   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  // Misalignment wins over out-of-range.
  function automatic logic [1:0] addr_fault(input logic [ADDR_WIDTH-1:0] a);
    if (a[1:0] != 2'b00) return F_MIS;
    if ((a >> 2) >= DEPTH_A) return F_OOR;
    return F_OK;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Power-up contents only; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            pfault_q, pfault_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [1:0]            fault_q, fault_d;
  logic                  perr_q, perr_d;

  logic                  accept;
  logic                  prog_ok;

  assign accept  = fetch_req_i && (state_q != S_WAIT);
  assign prog_ok = prog_we_i && (addr_fault(prog_addr_i) == F_OK);
  assign perr_d  = prog_we_i && (addr_fault(prog_addr_i) != F_OK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pfault_d = pfault_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: begin
        // IDLE and RESP accept identically, so back-to-back fetches have no bubble.
        state_d = S_IDLE;
        if (accept) begin
          idx_d    = word_idx(fetch_addr_i);
          pfault_d = addr_fault(fetch_addr_i);
          cnt_d    = WS;
          state_d  = (WS != 4'd0) ? S_WAIT : S_RESP;
        end
      end
    endcase
  end

  // idx_d/pfault_d always name the request being answered whenever the next
  // state is RESP, whether it came straight from acceptance or out of WAIT.
  always_comb begin
    instr_d = instr_q;
    fault_d = fault_q;
    if (state_d == S_RESP) begin
      fault_d = pfault_d;
      if (pfault_d != F_OK)
        instr_d = '0;
      else if (prog_ok && (word_idx(prog_addr_i) == idx_d))
        instr_d = prog_data_i;
      else
        instr_d = mem[idx_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      pfault_q <= F_OK;
      instr_q  <= '0;
      fault_q  <= F_OK;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pfault_q <= pfault_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (prog_ok) mem[word_idx(prog_addr_i)] <= prog_data_i;
  end

  assign fetch_ready_o = (state_q != S_WAIT);
  assign fetch_valid_o = (state_q == S_RESP);
  assign fetch_instr_o = instr_q;
  assign fetch_fault_o = fault_q;
  assign prog_err_o    = perr_q;

endmodule
